// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the IC/DC memory-port arbiter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    // Width of one memory data beat and number of beats per read response.
    localparam int MEM_DATA_BITS = 128;
    localparam int MEM_BEATS     = 4;

    // Arbiter state encodings; kept as plain constants so legacy code can share them.
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WRITE_DATA = 2'd1;
    localparam logic [1:0] ST_READ_RESP  = 2'd2;

    // Port indices used for the pri and owner registers.
    localparam logic PORT_IC = 1'b0;
    localparam logic PORT_DC = 1'b1;

    // The other cache port, used for round-robin hand-off.
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/mem_arb_beat_counter.sv
// Counts read-response beats and flags the final beat of a transaction.
// Latency: count updates one cycle after inc; last is combinational from count.
// Backpressure: none; counts only the beats it is told about.
module mem_arb_beat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int BEATS = MEM_BEATS,
    parameter int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] count;

    assign last = (count == CNT_W'(BEATS - 1));

    // Beat counter: restart on a new grant, wrap to zero after the final beat.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between the instruction and data caches, one transaction at a time.
// Latency: zero added latency on the request, write-data and response paths (combinational steering).
// Backpressure: only the granted/offered port sees memory ready; readies never depend on any valid input.
module mem_arbiter
#(
    parameter int ADDR_W = 28,
    parameter int DATA_W = mem_arbiter_pkg::MEM_DATA_BITS,
    parameter int BEATS  = mem_arbiter_pkg::MEM_BEATS
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ic_mem_req_valid,
    output logic                ic_mem_req_ready,
    input  logic [ADDR_W-1:0]   ic_mem_req_addr,
    input  logic                ic_mem_req_rw,
    input  logic                ic_mem_req_data_valid,
    output logic                ic_mem_req_data_ready,
    input  logic [DATA_W-1:0]   ic_mem_req_data_bits,
    input  logic [DATA_W/8-1:0] ic_mem_req_data_mask,
    output logic                ic_mem_resp_valid,
    output logic [DATA_W-1:0]   ic_mem_resp_data,

    input  logic                dc_mem_req_valid,
    output logic                dc_mem_req_ready,
    input  logic [ADDR_W-1:0]   dc_mem_req_addr,
    input  logic                dc_mem_req_rw,
    input  logic                dc_mem_req_data_valid,
    output logic                dc_mem_req_data_ready,
    input  logic [DATA_W-1:0]   dc_mem_req_data_bits,
    input  logic [DATA_W/8-1:0] dc_mem_req_data_mask,
    output logic                dc_mem_resp_valid,
    output logic [DATA_W-1:0]   dc_mem_resp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_rw,
    output logic                mem_req_data_valid,
    input  logic                mem_req_data_ready,
    output logic [DATA_W-1:0]   mem_req_data_bits,
    output logic [DATA_W/8-1:0] mem_req_data_mask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,

    output logic                err_stray_resp
);

    import mem_arbiter_pkg::*;

    logic [1:0] state;
    logic       owner;
    logic       pri;

    logic       in_idle;
    logic       in_wdata;
    logic       in_rresp;
    logic       pri_valid;
    logic       pri_rw;
    logic       owner_data_valid;
    logic       accept;
    logic       wdata_done;
    logic       beat_inc;
    logic       beat_last;

    // Reset forces every state-qualified strobe low, which silences all handshakes.
    assign in_idle  = !reset && (state == ST_IDLE);
    assign in_wdata = !reset && (state == ST_WRITE_DATA);
    assign in_rresp = !reset && (state == ST_READ_RESP);

    // Request path: only the offered port is visible to memory.
    assign pri_valid     = (pri == PORT_DC) ? dc_mem_req_valid : ic_mem_req_valid;
    assign pri_rw        = (pri == PORT_DC) ? dc_mem_req_rw    : ic_mem_req_rw;
    assign mem_req_addr  = (pri == PORT_DC) ? dc_mem_req_addr  : ic_mem_req_addr;
    assign mem_req_rw    = pri_rw;
    assign mem_req_valid = in_idle && mem_req_ready && pri_valid;
    assign accept        = mem_req_valid;

    // Caches raise valid from ready, so ready is built from state, pri and memory ready only.
    assign ic_mem_req_ready = in_idle && (pri == PORT_IC) && mem_req_ready;
    assign dc_mem_req_ready = in_idle && (pri == PORT_DC) && mem_req_ready;

    // Write-data path: the owner's single beat goes straight through.
    assign owner_data_valid   = (owner == PORT_DC) ? dc_mem_req_data_valid : ic_mem_req_data_valid;
    assign mem_req_data_valid = in_wdata && owner_data_valid;
    assign mem_req_data_bits  = (owner == PORT_DC) ? dc_mem_req_data_bits : ic_mem_req_data_bits;
    assign mem_req_data_mask  = (owner == PORT_DC) ? dc_mem_req_data_mask : ic_mem_req_data_mask;
    assign ic_mem_req_data_ready = in_wdata && (owner == PORT_IC) && mem_req_data_ready;
    assign dc_mem_req_data_ready = in_wdata && (owner == PORT_DC) && mem_req_data_ready;
    assign wdata_done = mem_req_data_valid && mem_req_data_ready;

    // Response path: data is broadcast, valid only reaches the owner during a read.
    assign ic_mem_resp_data  = mem_resp_data;
    assign dc_mem_resp_data  = mem_resp_data;
    assign ic_mem_resp_valid = in_rresp && (owner == PORT_IC) && mem_resp_valid;
    assign dc_mem_resp_valid = in_rresp && (owner == PORT_DC) && mem_resp_valid;
    assign beat_inc = in_rresp && mem_resp_valid;

    mem_arb_beat_counter #(
        .BEATS (BEATS)
    ) u_beat_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .inc   (beat_inc),
        .last  (beat_last)
    );

    // Grant FSM: pri alternates every idle cycle and hands off to the other port on a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            pri   <= PORT_DC;
            owner <= PORT_DC;
        end else begin
            case (state)
                ST_IDLE: begin
                    pri <= other_port(pri);
                    if (accept) begin
                        owner <= pri;
                        state <= pri_rw ? ST_WRITE_DATA : ST_READ_RESP;
                    end
                end
                ST_WRITE_DATA: begin
                    if (wdata_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_READ_RESP: begin
                    if (beat_inc && beat_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error: any response beat outside a read transaction is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_stray_resp <= 1'b0;
        end else if (mem_resp_valid && (state != ST_READ_RESP)) begin
            err_stray_resp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, write-data and response steering, stray beats, reset.
// Latency: n/a.
// Backpressure: exercised on both the request and the write-data handshakes.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int MASK_W = DATA_W / 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic              ic_mem_req_valid, ic_mem_req_ready, ic_mem_req_rw;
    logic [ADDR_W-1:0] ic_mem_req_addr;
    logic              ic_mem_req_data_valid, ic_mem_req_data_ready;
    logic [DATA_W-1:0] ic_mem_req_data_bits;
    logic [MASK_W-1:0] ic_mem_req_data_mask;
    logic              ic_mem_resp_valid;
    logic [DATA_W-1:0] ic_mem_resp_data;

    logic              dc_mem_req_valid, dc_mem_req_ready, dc_mem_req_rw;
    logic [ADDR_W-1:0] dc_mem_req_addr;
    logic              dc_mem_req_data_valid, dc_mem_req_data_ready;
    logic [DATA_W-1:0] dc_mem_req_data_bits;
    logic [MASK_W-1:0] dc_mem_req_data_mask;
    logic              dc_mem_resp_valid;
    logic [DATA_W-1:0] dc_mem_resp_data;

    logic              mem_req_valid, mem_req_ready, mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_data_valid, mem_req_data_ready;
    logic [DATA_W-1:0] mem_req_data_bits;
    logic [MASK_W-1:0] mem_req_data_mask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              err_stray_resp;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(4)) dut (
        .clk(clk), .reset(reset),
        .ic_mem_req_valid(ic_mem_req_valid), .ic_mem_req_ready(ic_mem_req_ready),
        .ic_mem_req_addr(ic_mem_req_addr), .ic_mem_req_rw(ic_mem_req_rw),
        .ic_mem_req_data_valid(ic_mem_req_data_valid), .ic_mem_req_data_ready(ic_mem_req_data_ready),
        .ic_mem_req_data_bits(ic_mem_req_data_bits), .ic_mem_req_data_mask(ic_mem_req_data_mask),
        .ic_mem_resp_valid(ic_mem_resp_valid), .ic_mem_resp_data(ic_mem_resp_data),
        .dc_mem_req_valid(dc_mem_req_valid), .dc_mem_req_ready(dc_mem_req_ready),
        .dc_mem_req_addr(dc_mem_req_addr), .dc_mem_req_rw(dc_mem_req_rw),
        .dc_mem_req_data_valid(dc_mem_req_data_valid), .dc_mem_req_data_ready(dc_mem_req_data_ready),
        .dc_mem_req_data_bits(dc_mem_req_data_bits), .dc_mem_req_data_mask(dc_mem_req_data_mask),
        .dc_mem_resp_valid(dc_mem_resp_valid), .dc_mem_resp_data(dc_mem_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .err_stray_resp(err_stray_resp)
    );

    // Deassert every cache/memory input; memory readies default high.
    task automatic clear_inputs();
        ic_mem_req_valid = 0; ic_mem_req_addr = '0; ic_mem_req_rw = 0;
        ic_mem_req_data_valid = 0; ic_mem_req_data_bits = '0; ic_mem_req_data_mask = '0;
        dc_mem_req_valid = 0; dc_mem_req_addr = '0; dc_mem_req_rw = 0;
        dc_mem_req_data_valid = 0; dc_mem_req_data_bits = '0; dc_mem_req_data_mask = '0;
        mem_req_ready = 1; mem_req_data_ready = 1; mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    // Two-cycle reset; returns at a falling edge with reset just released (pri = DC).
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1;
        ic_mem_req_valid = 1; dc_mem_req_valid = 1;
        ic_mem_req_data_valid = 1; dc_mem_req_data_valid = 1;
        mem_req_ready = 1; mem_req_data_ready = 1; mem_resp_valid = 1;
        #1;
        vectors++;
        if ({ic_mem_req_ready, dc_mem_req_ready, ic_mem_req_data_ready, dc_mem_req_data_ready,
             ic_mem_resp_valid, dc_mem_resp_valid, mem_req_valid, mem_req_data_valid} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 00000000", {ic_mem_req_ready, dc_mem_req_ready,
                ic_mem_req_data_ready, dc_mem_req_data_ready, ic_mem_resp_valid, dc_mem_resp_valid,
                mem_req_valid, mem_req_data_valid});
        end
        @(posedge clk); #1;
        vectors++;
        if ({dut.state, dut.pri, dut.owner, err_stray_resp} !== {ST_IDLE, PORT_DC, PORT_DC, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_regs: got state=%0d pri=%0b owner=%0b err=%0b want 0 1 1 0",
                     dut.state, dut.pri, dut.owner, err_stray_resp);
        end
        vectors++;
        if (dut.u_beat_cnt.count !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d want 0", dut.u_beat_cnt.count);
        end
        do_reset();
    endtask

    task automatic test_dc_read();
        logic [DATA_W-1:0] d;
        do_reset();
        dc_mem_req_valid = 1; dc_mem_req_addr = 28'h0000010; dc_mem_req_rw = 0;
        #1;
        vectors++;
        if ({mem_req_valid, mem_req_addr, mem_req_rw, ic_mem_req_ready, dc_mem_req_ready} !==
            {1'b1, 28'h0000010, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rd_req: got v=%0b a=%h rw=%0b ic_rdy=%0b dc_rdy=%0b want 1 0000010 0 0 1",
                     mem_req_valid, mem_req_addr, mem_req_rw, ic_mem_req_ready, dc_mem_req_ready);
        end
        @(negedge clk);
        dc_mem_req_valid = 0;
        #1;
        vectors++;
        if ({dut.state, ic_mem_req_ready, dc_mem_req_ready} !== {ST_READ_RESP, 2'b00}) begin
            miscompares++;
            $display("FAIL rd_state: got state=%0d rdy=%b%b want 2 00", dut.state,
                     ic_mem_req_ready, dc_mem_req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d = {32'hD0D0_D0D0, 32'h1111_2222, 32'h3333_4444, 32'(i)};
            mem_resp_valid = 1; mem_resp_data = d;
            #1;
            vectors++;
            if ({ic_mem_resp_valid, dc_mem_resp_valid, dc_mem_resp_data, ic_mem_resp_data} !==
                {2'b01, d, d}) begin
                miscompares++;
                $display("FAIL rd_beat%0d: got ic_v=%0b dc_v=%0b dc_d=%h want 0 1 %h", i,
                         ic_mem_resp_valid, dc_mem_resp_valid, dc_mem_resp_data, d);
            end
        end
        @(negedge clk);
        mem_resp_valid = 0;
        #1;
        vectors++;
        if ({dut.state, dc_mem_resp_valid, err_stray_resp} !== {ST_IDLE, 2'b00}) begin
            miscompares++;
            $display("FAIL rd_done: got state=%0d dc_v=%0b err=%0b want 0 0 0", dut.state,
                     dc_mem_resp_valid, err_stray_resp);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ic_mem_req_valid = 1; ic_mem_req_addr = 28'h100; ic_mem_req_rw = 0;
        dc_mem_req_valid = 1; dc_mem_req_addr = 28'h200; dc_mem_req_rw = 1;
        dc_mem_req_data_valid = 1; dc_mem_req_data_bits = 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_F0F0;
        dc_mem_req_data_mask = 16'h000F;
        #1;
        vectors++;
        if ({mem_req_addr, mem_req_rw, ic_mem_req_ready, dc_mem_req_ready} !== {28'h200, 1'b1, 2'b01}) begin
            miscompares++;
            $display("FAIL sim_dc_first: got a=%h rw=%0b rdy=%b%b want 0000200 1 01", mem_req_addr,
                     mem_req_rw, ic_mem_req_ready, dc_mem_req_ready);
        end
        @(negedge clk);
        dc_mem_req_valid = 0;
        #1;
        vectors++;
        if ({mem_req_data_valid, mem_req_data_mask, mem_req_data_bits, ic_mem_req_data_ready,
             dc_mem_req_data_ready, ic_mem_req_ready} !==
            {1'b1, 16'h000F, 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_F0F0, 3'b010}) begin
            miscompares++;
            $display("FAIL sim_wbeat: got v=%0b m=%h d=%h drdy=%b%b ic_rdy=%0b want 1 000f a5a5.. 01 0",
                     mem_req_data_valid, mem_req_data_mask, mem_req_data_bits, ic_mem_req_data_ready,
                     dc_mem_req_data_ready, ic_mem_req_ready);
        end
        @(negedge clk);
        dc_mem_req_data_valid = 0;
        #1;
        vectors++;
        if ({mem_req_valid, mem_req_addr, mem_req_rw, ic_mem_req_ready, dc_mem_req_ready} !==
            {1'b1, 28'h100, 1'b0, 2'b10}) begin
            miscompares++;
            $display("FAIL sim_ic_next: got v=%0b a=%h rw=%0b rdy=%b%b want 1 0000100 0 10",
                     mem_req_valid, mem_req_addr, mem_req_rw, ic_mem_req_ready, dc_mem_req_ready);
        end
        @(negedge clk);
        ic_mem_req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            mem_resp_valid = 1; mem_resp_data = 128'(32'hC0DE_0000 + i);
            #1;
            vectors++;
            if ({ic_mem_resp_valid, dc_mem_resp_valid} !== 2'b10) begin
                miscompares++;
                $display("FAIL sim_ic_beat%0d: got %b%b want 10", i, ic_mem_resp_valid, dc_mem_resp_valid);
            end
        end
        // Repeat with two reads issued together: DC wins now, IC right after.
        @(negedge clk);
        mem_resp_valid = 0;
        ic_mem_req_valid = 1; ic_mem_req_addr = 28'h100; ic_mem_req_rw = 0;
        dc_mem_req_valid = 1; dc_mem_req_addr = 28'h200; dc_mem_req_rw = 0;
        #1;
        vectors++;
        if ({mem_req_addr, ic_mem_req_ready, dc_mem_req_ready} !== {28'h200, 2'b01}) begin
            miscompares++;
            $display("FAIL rep_dc_first: got a=%h rdy=%b%b want 0000200 01", mem_req_addr,
                     ic_mem_req_ready, dc_mem_req_ready);
        end
        @(negedge clk);
        dc_mem_req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            mem_resp_valid = 1; mem_resp_data = 128'(i);
            #1;
            vectors++;
            if ({ic_mem_resp_valid, dc_mem_resp_valid} !== 2'b01) begin
                miscompares++;
                $display("FAIL rep_dc_beat%0d: got %b%b want 01", i, ic_mem_resp_valid, dc_mem_resp_valid);
            end
        end
        @(negedge clk);
        mem_resp_valid = 0;
        #1;
        vectors++;
        if ({mem_req_valid, mem_req_addr, ic_mem_req_ready} !== {1'b1, 28'h100, 1'b1}) begin
            miscompares++;
            $display("FAIL rep_ic_b2b: got v=%0b a=%h ic_rdy=%0b want 1 0000100 1", mem_req_valid,
                     mem_req_addr, ic_mem_req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if ({dut.state, dut.owner} !== {ST_READ_RESP, PORT_IC}) begin
            miscompares++;
            $display("FAIL rep_ic_owner: got state=%0d owner=%0b want 2 0", dut.state, dut.owner);
        end
    endtask

    task automatic test_req_stall();
        int waited;
        do_reset();
        ic_mem_req_valid = 1; ic_mem_req_addr = 28'h300; ic_mem_req_rw = 0;
        mem_req_ready = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            vectors++;
            if ({ic_mem_req_ready, dc_mem_req_ready, mem_req_valid, dut.state} !== {3'b000, ST_IDLE}) begin
                miscompares++;
                $display("FAIL stall_cyc%0d: got rdy=%b%b v=%0b state=%0d want 00 0 0", i,
                         ic_mem_req_ready, dc_mem_req_ready, mem_req_valid, dut.state);
            end
        end
        @(negedge clk);
        mem_req_ready = 1;
        waited = 0;
        while (dut.state == ST_IDLE && waited < 3) begin
            @(posedge clk); #1;
            waited++;
        end
        vectors++;
        if (!(dut.state == ST_READ_RESP && dut.owner == PORT_IC && waited <= 2)) begin
            miscompares++;
            $display("FAIL stall_grant: got state=%0d owner=%0b cycles=%0d want 2 0 <=2",
                     dut.state, dut.owner, waited);
        end
    endtask

    task automatic test_wdata_stall();
        do_reset();
        dc_mem_req_valid = 1; dc_mem_req_addr = 28'h400; dc_mem_req_rw = 1;
        dc_mem_req_data_valid = 1; dc_mem_req_data_bits = 128'hFEED_BEEF_0000_0000_1111_2222_3333_4444;
        dc_mem_req_data_mask = 16'hFFFF;
        mem_req_data_ready = 0;
        @(negedge clk);
        dc_mem_req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            vectors++;
            if ({dut.state, dc_mem_req_data_ready, mem_req_data_valid} !== {ST_WRITE_DATA, 2'b01}) begin
                miscompares++;
                $display("FAIL wstall_cyc%0d: got state=%0d drdy=%0b dv=%0b want 1 0 1", i,
                         dut.state, dc_mem_req_data_ready, mem_req_data_valid);
            end
        end
        @(negedge clk);
        mem_req_data_ready = 1;
        #1;
        vectors++;
        if ({dc_mem_req_data_ready, mem_req_data_valid, mem_req_data_bits} !==
            {2'b11, 128'hFEED_BEEF_0000_0000_1111_2222_3333_4444}) begin
            miscompares++;
            $display("FAIL wstall_fwd: got drdy=%0b dv=%0b d=%h want 1 1 feedbeef..",
                     dc_mem_req_data_ready, mem_req_data_valid, mem_req_data_bits);
        end
        @(posedge clk); #1;
        vectors++;
        if (dut.state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL wstall_idle: got state=%0d want 0", dut.state);
        end
        dc_mem_req_data_valid = 0;
    endtask

    task automatic test_stray();
        do_reset();
        mem_resp_valid = 1; mem_resp_data = 128'hBAD;
        #1;
        vectors++;
        if ({ic_mem_resp_valid, dc_mem_resp_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL stray_drop: got %b%b want 00", ic_mem_resp_valid, dc_mem_resp_valid);
        end
        @(negedge clk);
        mem_resp_valid = 0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (err_stray_resp !== 1'b1) begin
            miscompares++;
            $display("FAIL stray_sticky: got %0b want 1", err_stray_resp);
        end
        reset = 1;
        @(posedge clk); #1;
        vectors++;
        if (err_stray_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_clear: got %0b want 0", err_stray_resp);
        end
        reset = 0;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        dc_mem_req_valid = 1; dc_mem_req_addr = 28'h500; dc_mem_req_rw = 0;
        @(negedge clk);
        dc_mem_req_valid = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_resp_valid = 1; mem_resp_data = 128'(i);
        end
        @(negedge clk);
        mem_resp_valid = 0;
        #1;
        vectors++;
        if ({dut.state, dut.u_beat_cnt.count} !== {ST_READ_RESP, 2'd2}) begin
            miscompares++;
            $display("FAIL mid_pre: got state=%0d count=%0d want 2 2", dut.state, dut.u_beat_cnt.count);
        end
        reset = 1;
        @(posedge clk); #1;
        vectors++;
        if ({dut.state, dut.u_beat_cnt.count, dut.pri} !== {ST_IDLE, 2'd0, PORT_DC}) begin
            miscompares++;
            $display("FAIL mid_reset: got state=%0d count=%0d pri=%0b want 0 0 1", dut.state,
                     dut.u_beat_cnt.count, dut.pri);
        end
        @(negedge clk);
        reset = 0;
        for (int i = 2; i < 4; i++) begin
            if (i > 2) @(negedge clk);
            mem_resp_valid = 1; mem_resp_data = 128'(i);
            #1;
            vectors++;
            if ({ic_mem_resp_valid, dc_mem_resp_valid} !== 2'b00) begin
                miscompares++;
                $display("FAIL mid_late%0d: got %b%b want 00", i, ic_mem_resp_valid, dc_mem_resp_valid);
            end
        end
        @(negedge clk);
        mem_resp_valid = 0;
        #1;
        vectors++;
        if (err_stray_resp !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_err: got %0b want 1", err_stray_resp);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_dc_read();
        test_simultaneous();
        test_req_stall();
        test_wdata_stall();
        test_stray();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing-memory port between the instruction cache (IC) and the data cache (DC).
- Each cache port uses the cache-to-memory protocol: request with addr/rw, one write data beat, and 4-beat read responses.
- Grants one transaction at a time and steers the handshakes, data and responses to the owner. The request path is a combinational pass-through with zero added latency.
- Sits between the two cache instances and the top-level memory interface.

Parameters:
ADDR_W, 28, memory line address width (word address bits minus 2)
DATA_W, 128, memory data beat width (MEM_DATA_BITS)
BEATS, 4, response beats per read transaction

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ic_mem_req_valid / dc_mem_req_valid  in  1  per-port request valid
ic_mem_req_ready / dc_mem_req_ready  out  1  per-port request ready
ic_mem_req_addr / dc_mem_req_addr  in  ADDR_W  request line address
ic_mem_req_rw / dc_mem_req_rw  in  1  request type: 1 = write, 0 = read
ic_mem_req_data_valid / dc_mem_req_data_valid  in  1  write data beat valid
ic_mem_req_data_ready / dc_mem_req_data_ready  out  1  write data beat ready
ic_mem_req_data_bits / dc_mem_req_data_bits  in  DATA_W  write data
ic_mem_req_data_mask / dc_mem_req_data_mask  in  DATA_W/8  write byte mask
ic_mem_resp_valid / dc_mem_resp_valid  out  1  response beat valid (owner only)
ic_mem_resp_data / dc_mem_resp_data  out  DATA_W  response data (broadcast to both)
mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid, mem_req_data_bits, mem_req_data_mask  out  -  to memory; widths as above
mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data  in  -  from memory; widths as above
err_stray_resp  out  1  sticky flag: mem_resp_valid arrived outside READ_RESP

Behaviour:
- Registers:
  - state: IDLE, WRITE_DATA, READ_RESP.
  - owner: 0 = IC, 1 = DC.
  - pri: port offered the grant.
  - beat count: log2(BEATS) bits.
  - err_stray_resp.
- Reset values: state = IDLE, pri = DC, owner = DC, count = 0, err_stray_resp = 0.
- While reset is high, all per-port ready/valid outputs and mem_req_valid/mem_req_data_valid are driven 0.
- Loop-free rule: the caches assert req_valid combinationally from req_ready. Therefore no ready output may depend on any valid input.
- IDLE:
  - pri port sees req_ready = mem_req_ready; the other port sees 0.
  - mem_req_valid/addr/rw = pri port's signals, gated by mem_req_ready.
  - Accept (pri valid && mem_req_ready):
    - owner <= pri; pri <= other port (round-robin).
    - rw = 1 -> WRITE_DATA; rw = 0 -> READ_RESP with count <= 0.
  - No accept: pri toggles every cycle. A lone requester therefore waits at most 1 extra cycle.
- WRITE_DATA:
  - Owner's data_ready = mem_req_data_ready; the other port's data_ready = 0.
  - mem_req_data_valid/bits/mask = owner's signals.
  - On owner data_valid && mem_req_data_ready -> IDLE.
  - No request ready is offered in this state.
- READ_RESP:
  - Owner's resp_valid = mem_resp_valid; the other port's resp_valid = 0.
  - Each beat increments count. On the beat with count == BEATS-1 -> IDLE and count <= 0.
  - No request ready is offered.
- Write hits complete in WRITE_DATA only; no read response is expected for writes.
- mem_resp_data is broadcast unconditionally to both ports' resp_data.
- A mem_resp_valid in IDLE or WRITE_DATA is dropped and sets err_stray_resp, which stays set until reset.
- Reset mid-transaction: returns to IDLE immediately and discards any in-flight beats. Responses arriving after reset set err_stray_resp.
- Back-to-back transactions: a new request can be accepted in the cycle after the last read beat or the write data beat.

Decomposition:
- Shared package/header (const.vh):
  - MEM_DATA_BITS and the BEATS constant.
  - State encodings IDLE/WRITE_DATA/READ_RESP.
  - Port index constants PORT_IC = 0, PORT_DC = 1.
- Optional sub-module: mem_arb_beat_counter (beat counter with terminal-count output).
- All other logic is a single module.

Test Plan:
- DC read only, mem_req_ready = 1:
  - DC issues a read to addr 0x0000010 in cycle 1, then 4 beats D0..D3 arrive.
  - Required: mem_req_valid in cycle 1 or 2.
  - Required: dc_mem_resp_valid on exactly 4 cycles with data D0..D3; ic_mem_resp_valid stays 0; state returns to IDLE.
- Simultaneous IC read 0x100 and DC write 0x200 after reset (pri = DC):
  - Required: DC write granted first; mask 0x000F is forwarded on the data beat.
  - Required: IC is granted on the next IDLE cycle and receives 4 beats; the grant order alternates on repeats.
- mem_req_ready = 0 for 5 cycles with IC pending:
  - Required: no grant and both readies 0.
  - Required: grant within 2 cycles of ready rising.
- Write data backpressure: hold mem_req_data_ready low for 3 cycles.
  - Required: state stays WRITE_DATA and dc_mem_req_data_ready = 0.
  - Required: the beat is forwarded on the cycle ready rises, then IDLE.
- Stray beat: mem_resp_valid pulse while in IDLE.
  - Required: neither resp_valid asserts; err_stray_resp = 1 until reset.
- Reset after the 2nd read beat:
  - Required: IDLE next cycle; count = 0; pri = DC.
  - Required: subsequent beats set err_stray_resp and reach neither port.
